// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rx, mid-bit sampling FSM, one-cycle FIFO write strobe.
// Optional parity bit and check enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int PARITY_ODD   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx,
   input  logic                  full,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  parity_err,
   output logic                  overrun_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] BIT_LAST = IW'(DATA_WIDTH - 1);

   if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks
      $error("uart_rx: CLKS_PER_BIT must be even and >= 4");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
      $error("uart_rx: PARITY_ODD must be 0 or 1");
   end

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [IW-1:0]         r_bit_idx;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic                  r_rx_meta, r_rx_s, r_rx_prev;
   logic [1:0]            r_rdy;
   logic                  r_armed;
   logic                  r_wr_en, r_frame_err, r_overrun_err;
   logic                  w_par_err;

`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   logic r_par_bit;
   logic r_parity_err;
   assign w_par_err  = (^r_shift) ^ r_par_bit ^ PAR_ODD;
   assign parity_err = r_parity_err;
`else
   assign w_par_err  = 1'b0;
   assign parity_err = 1'b0;
`endif

   // The synchronizer comes out of reset holding 1s that were never seen on
   // the line; r_armed blocks start detection until a genuine high has passed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_bit_idx     <= '0;
         r_shift       <= '0;
         r_wr_data     <= '0;
         r_rx_meta     <= 1'b1;
         r_rx_s        <= 1'b1;
         r_rx_prev     <= 1'b1;
         r_rdy         <= 2'b00;
         r_armed       <= 1'b0;
         r_wr_en       <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit     <= 1'b0;
         r_parity_err  <= 1'b0;
`endif
      end else begin
         r_rx_meta     <= rx;
         r_rx_s        <= r_rx_meta;
         r_rx_prev     <= r_rx_s;
         r_rdy         <= {r_rdy[0], 1'b1};
         if (r_rdy[1] && r_rx_s) r_armed <= 1'b1;
         r_wr_en       <= 1'b0;
         r_frame_err   <= 1'b0;
         r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_parity_err  <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (r_armed && r_rx_prev && !r_rx_s) begin
                  r_state <= START;
                  r_cnt   <= '0;
               end
            end
            START: begin
               if (r_cnt == CNT_MID) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_state   <= r_rx_s ? IDLE : DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DATA: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt     <= '0;
                  r_shift   <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
                  r_bit_idx <= r_bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                  if (r_bit_idx == BIT_LAST) r_state <= PARITY;
`else
                  if (r_bit_idx == BIT_LAST) r_state <= STOP;
`endif
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt     <= '0;
                  r_par_bit <= r_rx_s;
                  r_state   <= STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= IDLE;
                  if (!r_rx_s) begin
                     r_frame_err <= 1'b1;
                  end else if (w_par_err) begin
`ifdef UART_RX_PARITY_EN
                     r_parity_err <= 1'b1;
`endif
                  end else if (full) begin
                     r_overrun_err <= 1'b1;
                  end else begin
                     r_wr_en   <= 1'b1;
                     r_wr_data <= r_shift;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign wr_en       = r_wr_en;
   assign wr_data     = r_wr_data;
   assign frame_err   = r_frame_err;
   assign overrun_err = r_overrun_err;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; parity scenarios run when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       full = 1'b0;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       busy, frame_err, parity_err, overrun_err;

  int n_vec = 0;
  int n_miss = 0;

  // running pulse-cycle counts; tests compare deltas across a frame
  int mon_wr = 0, mon_fe = 0, mon_pe = 0, mon_oe = 0;
  logic [7:0] mon_data = 8'h00;
  int s_wr, s_fe, s_pe, s_oe;
  logic mid_busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .full(full),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      mon_wr = mon_wr + 1;
      mon_data = wr_data;
    end
    if (frame_err) mon_fe = mon_fe + 1;
    if (parity_err) mon_pe = mon_pe + 1;
    if (overrun_err) mon_oe = mon_oe + 1;
  end

  // driver tasks: all driving happens right after a falling edge
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic snap();
    s_wr = mon_wr; s_fe = mon_fe; s_pe = mon_pe; s_oe = mon_oe;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB / 2) @(negedge clk);
      if (i == 4) mid_busy = busy;
      repeat (CPB / 2) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit === 1'bx) mid_busy = 1'bx;
`endif
    drive_bit(stop_bit);
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; full = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (wr_en !== 1'b0) begin n_miss++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_vec++; if (wr_data !== 8'h00) begin n_miss++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (frame_err !== 1'b0) begin n_miss++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_vec++; if (parity_err !== 1'b0) begin n_miss++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    n_vec++; if (overrun_err !== 1'b0) begin n_miss++; $display("FAIL reset_overrun_err: got %b want 0", overrun_err); end
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_good_frame();
    snap();
    mid_busy = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b1);
    n_vec++; if (mon_wr - s_wr !== 1) begin n_miss++; $display("FAIL a5_wr_count: got %0d want 1", mon_wr - s_wr); end
    n_vec++; if (mon_data !== 8'hA5) begin n_miss++; $display("FAIL a5_data: got %h want a5", mon_data); end
    n_vec++; if (mon_fe + mon_pe + mon_oe - s_fe - s_pe - s_oe !== 0) begin n_miss++; $display("FAIL a5_errors: got %0d want 0", mon_fe + mon_pe + mon_oe - s_fe - s_pe - s_oe); end
    n_vec++; if (mid_busy !== 1'b1) begin n_miss++; $display("FAIL a5_busy_mid: got %b want 1", mid_busy); end
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL a5_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_overrun();
    snap();
    full = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1);
    full = 1'b0;
    n_vec++; if (mon_wr - s_wr !== 0) begin n_miss++; $display("FAIL ovr_wr_count: got %0d want 0", mon_wr - s_wr); end
    n_vec++; if (mon_oe - s_oe !== 1) begin n_miss++; $display("FAIL ovr_pulse: got %0d want 1", mon_oe - s_oe); end
    n_vec++; if (mon_fe - s_fe !== 0) begin n_miss++; $display("FAIL ovr_frame_err: got %0d want 0", mon_fe - s_fe); end
    snap();
    send_frame(8'h5A, 1'b0, 1'b1);
    n_vec++; if (mon_wr - s_wr !== 1) begin n_miss++; $display("FAIL 5a_wr_count: got %0d want 1", mon_wr - s_wr); end
    n_vec++; if (mon_data !== 8'h5A) begin n_miss++; $display("FAIL 5a_data: got %h want 5a", mon_data); end
    n_vec++; if (mon_oe - s_oe !== 0) begin n_miss++; $display("FAIL 5a_overrun: got %0d want 0", mon_oe - s_oe); end
  endtask

  task automatic test_frame_error();
    snap();
    send_frame(8'hFF, 1'b0, 1'b0);
    n_vec++; if (mon_fe - s_fe !== 1) begin n_miss++; $display("FAIL ferr_pulse: got %0d want 1", mon_fe - s_fe); end
    n_vec++; if (mon_wr - s_wr !== 0) begin n_miss++; $display("FAIL ferr_wr_count: got %0d want 0", mon_wr - s_wr); end
    n_vec++; if (mon_oe + mon_pe - s_oe - s_pe !== 0) begin n_miss++; $display("FAIL ferr_other_err: got %0d want 0", mon_oe + mon_pe - s_oe - s_pe); end
    n_vec++; if (wr_data !== 8'h5A) begin n_miss++; $display("FAIL ferr_data_hold: got %h want 5a", wr_data); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_glitch();
    snap();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL glitch_busy_start: got %b want 1", busy); end
    repeat (40) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL glitch_busy_after: got %b want 0", busy); end
    n_vec++; if (mon_wr - s_wr !== 0) begin n_miss++; $display("FAIL glitch_wr_count: got %0d want 0", mon_wr - s_wr); end
    n_vec++; if (mon_fe + mon_pe + mon_oe - s_fe - s_pe - s_oe !== 0) begin n_miss++; $display("FAIL glitch_errors: got %0d want 0", mon_fe + mon_pe + mon_oe - s_fe - s_pe - s_oe); end
  endtask

  task automatic test_reset_midframe();
    snap();
    // 0x81: start, bits 0..2 = 1,0,0, then reset in the middle of bit 3
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL mid_busy_before_rst: got %b want 1", busy); end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL mid_busy_in_rst: got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL mid_no_restart_low_line: got %b want 0", busy); end
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
    repeat (16) @(negedge clk);
    n_vec++; if (mon_wr - s_wr !== 0) begin n_miss++; $display("FAIL mid_aborted_wr: got %0d want 0", mon_wr - s_wr); end
    n_vec++; if (mon_fe + mon_pe + mon_oe - s_fe - s_pe - s_oe !== 0) begin n_miss++; $display("FAIL mid_aborted_err: got %0d want 0", mon_fe + mon_pe + mon_oe - s_fe - s_pe - s_oe); end
    snap();
    send_frame(8'h42, 1'b0, 1'b1);
    n_vec++; if (mon_wr - s_wr !== 1) begin n_miss++; $display("FAIL 42_wr_count: got %0d want 1", mon_wr - s_wr); end
    n_vec++; if (mon_data !== 8'h42) begin n_miss++; $display("FAIL 42_data: got %h want 42", mon_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    n_vec++; if (mon_wr - s_wr !== 1) begin n_miss++; $display("FAIL par_ok_wr: got %0d want 1", mon_wr - s_wr); end
    n_vec++; if (mon_data !== 8'h07) begin n_miss++; $display("FAIL par_ok_data: got %h want 07", mon_data); end
    n_vec++; if (mon_pe - s_pe !== 0) begin n_miss++; $display("FAIL par_ok_perr: got %0d want 0", mon_pe - s_pe); end
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    n_vec++; if (mon_wr - s_wr !== 0) begin n_miss++; $display("FAIL par_bad_wr: got %0d want 0", mon_wr - s_wr); end
    n_vec++; if (mon_pe - s_pe !== 1) begin n_miss++; $display("FAIL par_bad_perr: got %0d want 1", mon_pe - s_pe); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, the number of clk cycles per serial bit (even value, ≥4).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the number of data bits per frame.
REQ-003 SHALL have parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; it is used only when UART_RX_PARITY_EN is defined.
REQ-004 clk  input  1  single clock; the block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 rx  input  1  asynchronous serial line; idles high.
REQ-007 full  input  1  downstream FIFO full flag.
REQ-008 wr_en  output  1  one-cycle write strobe to the FIFO.
REQ-009 wr_data  output  DATA_WIDTH  received byte; valid while wr_en=1.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 parity_err  output  1  one-cycle pulse: parity mismatch.
REQ-013 overrun_err  output  1  one-cycle pulse: good frame dropped because full=1.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer (rx_s) before use; both flops reset to 1.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY exists only with UART_RX_PARITY_EN.
REQ-016 IDLE: when rx_s=0 and rx_s was 1 in the previous cycle, the block SHALL go to START with bit counter cnt=0.
REQ-017 START: when cnt=CLKS_PER_BIT/2-1, rx_s SHALL be sampled; 0 goes to DATA with cnt=0; 1 is a glitch and returns to IDLE with no pulse.
REQ-018 DATA/PARITY/STOP: one bit SHALL be sampled each time cnt=CLKS_PER_BIT-1, after which cnt SHALL reset to 0; the counter width is $clog2(CLKS_PER_BIT).
REQ-019 Data SHALL be LSB first, shifted into a DATA_WIDTH register; the transition out of DATA SHALL occur after bit DATA_WIDTH-1 is sampled.
REQ-020 Parity check: the XOR of data bits and the parity bit SHALL equal PARITY_ODD; otherwise the frame is errored.
REQ-021 STOP sample = 1, no parity error and full=0: wr_en=1 with wr_data=shift register for exactly one cycle, in the cycle after the sample.
REQ-022 STOP sample = 1, no parity error and full=1: no write; overrun_err pulses one cycle.
REQ-023 STOP sample = 0: frame_err pulses and no write occurs, even if full=0.
REQ-024 Parity error with STOP sample = 1: parity_err pulses and no write occurs.
REQ-025 Precedence: frame_err > parity_err > overrun_err; at most one error pulse per frame.
REQ-026 After the stop sample the block SHALL enter IDLE the next cycle; a new frame requires a fresh 1->0 edge on rx_s.
REQ-027 full SHALL be sampled only in the stop-sample cycle; wr_en SHALL never be asserted while full=1.
REQ-028 wr_data SHALL hold its last value between strobes.
REQ-029 rx activity during an active frame SHALL NOT restart the FSM; only the mid-bit samples matter.

Reset
REQ-030 rst_n=0 at a clk edge SHALL force IDLE, cnt=0, shift register=0, wr_data=0, wr_en=0, busy=0, all error pulses 0, and synchronizer flops=1.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no write and no error pulse.
REQ-032 After reset release, if rx is already low the block SHALL wait for a high-then-low edge before receiving.

Configuration
REQ-033 Macro UART_RX_PARITY_EN defined: one parity bit is received between the data bits and the stop bit, and parity checking is active.
REQ-034 Macro UART_RX_PARITY_EN undefined: there is no PARITY state, the frame is 1 start + DATA_WIDTH data + 1 stop bits, and parity_err is tied to 0.

Verification
REQ-035 All scenarios SHALL use CLKS_PER_BIT=16 with the macro undefined unless noted.
REQ-036 Send 0xA5 with full=0 -> exactly one wr_en pulse with wr_data=0xA5, no error pulses, and busy low again after the stop sample.
REQ-037 Send 0x3C with full=1 -> wr_en stays 0 and overrun_err pulses once; then send 0x5A with full=0 -> wr_data=0x5A.
REQ-038 Send 0xFF with the stop bit driven 0 -> frame_err pulses once and there is no wr_en.
REQ-039 Drive a 4-clock low glitch on an idle rx line -> returns to IDLE with no wr_en and no error pulse.
REQ-040 Assert rst_n=0 during bit 3 of 0x81, then send 0x42 -> only 0x42 is written.
REQ-041 With UART_RX_PARITY_EN defined and PARITY_ODD=0, send 0x07 with parity=1 -> write of 0x07; with parity=0 -> parity_err pulses and there is no write.
